cog_accumulator: RTL

COG_ACCUMULATOR -- requirements
Module: cog_accumulator

---
 rtl/cog_accumulator_pkg.sv | 27 ++
 rtl/cog_accumulator_if.sv | 17 +
 rtl/cog_accumulator.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/cog_accumulator_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | cog_pkg : shared types and constants for cog_accumulator              |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
package cog_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_FLUSH = 2'd2
    } cog_state_e;

    localparam int ERR_W             = 3;
    localparam int ERR_MISSING_TLAST = 0;
    localparam int ERR_EARLY_TLAST   = 1;
    localparam int ERR_ABORT         = 2;

    localparam logic [ERR_W-1:0] ERR_ABORT_MASK = 3'b100;

    // Counter width that stays at least one bit for degenerate 1-pixel geometries.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/cog_accumulator_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | cog_accumulator_if : video stream (no back-pressure) into the block   |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
interface cog_accumulator_if #(
    parameter int N = 8
) ();
    logic [3*N-1:0] tdata;
    logic           tvalid;
    logic           tuser;
    logic           tlast;

    modport master (output tdata, tvalid, tuser, tlast);
    modport slave  (input  tdata, tvalid, tuser, tlast);
endinterface
`default_nettype wire

// File: rtl/cog_accumulator.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | cog_accumulator : per-frame sums of w, w*x, w*y for centre of gravity |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module cog_accumulator
    import cog_pkg::*;
#(
    parameter int  N      = 8,
    parameter int  width  = 10,
    parameter int  height = 10,
    localparam int SW     = N + $clog2(width * height + 1),
    localparam int SWX    = SW + $clog2(width),
    localparam int SWY    = SW + $clog2(height)
) (
    input  logic             clk,
    input  logic             aresetn,
    cog_accumulator_if.slave s_axis,
    output logic [SW-1:0]    o_sum_w,
    output logic [SWX-1:0]   o_sum_wx,
    output logic [SWY-1:0]   o_sum_wy,
    output logic [ERR_W-1:0] o_err,
    output logic             o_valid
);
    localparam int XW = cnt_width(width);
    localparam int YW = cnt_width(height);

    logic [N-1:0]     w_img, w_mask, w_weight;
    logic             w_unused_lsb;
    logic             w_start, w_accept, w_last_col, w_line_end, w_last_line;
    logic [XW-1:0]    w_px;
    logic [YW-1:0]    w_py;
    logic [ERR_W-1:0] w_line_err;

    cog_state_e       state_q;
    logic [XW-1:0]    x_q, s1_x_q;
    logic [YW-1:0]    y_q, s1_y_q;
    logic [N-1:0]     s1_w_q;
    logic             s1_vld_q, s1_start_q, s1_abort_q, s1_end_q;
    logic [ERR_W-1:0] s1_err_q;

    logic [SW-1:0]    acc_w_q, acc_w_d, res_w_q;
    logic [SWX-1:0]   acc_wx_q, acc_wx_d, res_wx_q;
    logic [SWY-1:0]   acc_wy_q, acc_wy_d, res_wy_q;
    logic [ERR_W-1:0] err_q, err_d, res_err_q;
    logic             done_q;

    assign w_img        = s_axis.tdata[3*N-1:2*N];
    assign w_mask       = s_axis.tdata[2*N-1:N];
    assign w_unused_lsb = ^s_axis.tdata[N-1:0];
    assign w_weight     = (|w_mask) ? w_img : '0;

    assign w_start     = s_axis.tvalid && s_axis.tuser;
    assign w_accept    = w_start || (s_axis.tvalid && (state_q == ST_ACCUM));
    // A frame-start beat is always placed at (0,0), whatever the counters hold.
    assign w_px        = w_start ? '0 : x_q;
    assign w_py        = w_start ? '0 : y_q;
    assign w_last_col  = (w_px == XW'(width - 1));
    assign w_last_line = (w_py == YW'(height - 1));
    assign w_line_end  = s_axis.tlast || w_last_col;

    always_comb begin
        w_line_err                    = '0;
        w_line_err[ERR_MISSING_TLAST] = !s_axis.tlast && w_last_col;
        w_line_err[ERR_EARLY_TLAST]   = s_axis.tlast && !w_last_col;
    end

    // Frame control and stage 1: position tracking and registered beat attributes.
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            state_q    <= ST_IDLE;
            x_q        <= '0;
            y_q        <= '0;
            s1_vld_q   <= 1'b0;
            s1_start_q <= 1'b0;
            s1_abort_q <= 1'b0;
            s1_end_q   <= 1'b0;
            s1_err_q   <= '0;
            s1_w_q     <= '0;
            s1_x_q     <= '0;
            s1_y_q     <= '0;
        end else begin
            s1_vld_q   <= w_accept;
            s1_start_q <= w_start;
            s1_abort_q <= w_start && (state_q == ST_ACCUM);
            s1_end_q   <= w_accept && w_line_end && w_last_line;
            if (w_accept) begin
                s1_err_q <= w_line_err;
                s1_w_q   <= w_weight;
                s1_x_q   <= w_px;
                s1_y_q   <= w_py;
                if (w_line_end) begin
                    x_q <= '0;
                    if (w_last_line) begin
                        y_q     <= '0;
                        state_q <= ST_FLUSH;
                    end else begin
                        y_q     <= w_py + 1'b1;
                        state_q <= ST_ACCUM;
                    end
                end else begin
                    x_q     <= w_px + 1'b1;
                    y_q     <= w_py;
                    state_q <= ST_ACCUM;
                end
            end else if (state_q != ST_ACCUM) begin
                state_q <= ST_IDLE;
            end
        end
    end

    assign acc_w_d  = (s1_start_q ? '0 : acc_w_q) + SW'(s1_w_q);
    assign acc_wx_d = (s1_start_q ? '0 : acc_wx_q) + SWX'(s1_w_q) * SWX'(s1_x_q);
    assign acc_wy_d = (s1_start_q ? '0 : acc_wy_q) + SWY'(s1_w_q) * SWY'(s1_y_q);
    assign err_d    = (s1_start_q ? '0 : err_q) | s1_err_q;

    // Stage 2: running sums, plus a result snapshot so an abort can restart the sums in the same cycle.
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            acc_w_q   <= '0;
            acc_wx_q  <= '0;
            acc_wy_q  <= '0;
            err_q     <= '0;
            res_w_q   <= '0;
            res_wx_q  <= '0;
            res_wy_q  <= '0;
            res_err_q <= '0;
            done_q    <= 1'b0;
        end else begin
            done_q <= s1_abort_q || (s1_vld_q && s1_end_q);
            if (s1_vld_q) begin
                acc_w_q  <= acc_w_d;
                acc_wx_q <= acc_wx_d;
                acc_wy_q <= acc_wy_d;
                err_q    <= err_d;
            end
            if (s1_abort_q) begin
                res_w_q   <= acc_w_q;
                res_wx_q  <= acc_wx_q;
                res_wy_q  <= acc_wy_q;
                res_err_q <= err_q | ERR_ABORT_MASK;
            end else if (s1_vld_q && s1_end_q) begin
                res_w_q   <= acc_w_d;
                res_wx_q  <= acc_wx_d;
                res_wy_q  <= acc_wy_d;
                res_err_q <= err_d;
            end
        end
    end

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            o_sum_w  <= '0;
            o_sum_wx <= '0;
            o_sum_wy <= '0;
            o_err    <= '0;
            o_valid  <= 1'b0;
        end else begin
            o_valid <= done_q;
            if (done_q) begin
                o_sum_w  <= res_w_q;
                o_sum_wx <= res_wx_q;
                o_sum_wy <= res_wy_q;
                o_err    <= res_err_q;
            end
        end
    end

endmodule
`default_nettype wire
